// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback has priority, and coprocessor
// results are queued and drained into idle writeback cycles, with WAW kill and starvation stall.
module wb_port_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteW,
    input  logic [3:0]  WA3W,
    input  logic [31:0] ResultW,
    input  logic        cp_valid,
    input  logic [3:0]  cp_wa,
    input  logic [31:0] cp_data,
    output logic        cp_ready,
    output logic        rf_we,
    output logic [3:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic [15:0] pend_mask,
    output logic        stall_req
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {ST_NORMAL, ST_STARVED} state_t;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] kill_q, kill_d;
    logic [3:0]       wa_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];

    state_t           state_q;
    logic [STV_W-1:0] starve_q;
    logic             stall_req_q;

    logic head_valid, head_kill, head_live, issue, pop, push;

    always_comb begin
        cp_ready   = (count_q != CNT_W'(DEPTH));
        head_valid = valid_q[rd_ptr_q];
        head_kill  = head_valid & kill_q[rd_ptr_q];
        head_live  = head_valid & ~kill_q[rd_ptr_q];
        issue      = head_live & ~RegWriteW;
        pop        = issue | head_kill;
        push       = cp_valid & cp_ready;
    end

    // Kills apply only to entries already queued; the slot being pushed starts live.
    always_comb begin
        valid_d  = valid_q;
        kill_d   = kill_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (RegWriteW && valid_q[i] && (wa_q[i] == WA3W)) begin
                kill_d[i] = 1'b1;
            end
        end
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            kill_d[rd_ptr_q]  = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            valid_d[wr_ptr_q] = 1'b1;
            kill_d[wr_ptr_q]  = 1'b0;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            kill_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            kill_q   <= kill_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by valid_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            wa_q[wr_ptr_q]   <= cp_wa;
            data_q[wr_ptr_q] <= cp_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_NORMAL;
            starve_q    <= '0;
            stall_req_q <= 1'b0;
        end else begin
            case (state_q)
                ST_NORMAL: begin
                    if (!head_valid || issue) begin
                        starve_q <= '0;
                    end else if (head_live && RegWriteW) begin
                        if (starve_q == STV_W'(STARVE_LIMIT - 1)) begin
                            state_q     <= ST_STARVED;
                            stall_req_q <= 1'b1;
                            starve_q    <= '0;
                        end else begin
                            starve_q <= starve_q + STV_W'(1);
                        end
                    end
                end
                ST_STARVED: begin
                    if (issue || head_kill) begin
                        state_q     <= ST_NORMAL;
                        stall_req_q <= 1'b0;
                        starve_q    <= '0;
                    end
                end
                default: begin
                    state_q     <= ST_NORMAL;
                    stall_req_q <= 1'b0;
                    starve_q    <= '0;
                end
            endcase
        end
    end

    always_comb begin
        rf_we = 1'b0;
        rf_wa = 4'd0;
        rf_wd = 32'd0;
        if (RegWriteW) begin
            rf_we = 1'b1;
            rf_wa = WA3W;
            rf_wd = ResultW;
        end else if (head_live) begin
            rf_we = 1'b1;
            rf_wa = wa_q[rd_ptr_q];
            rf_wd = data_q[rd_ptr_q];
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && !kill_q[i]) begin
                pend_mask[wa_q[i]] = 1'b1;
            end
        end
    end

    assign stall_req = stall_req_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: a queue-based model checked every cycle plus directed literal checks.
module tb_wb_port_arbiter;
    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RegWriteW;
    logic [3:0]  WA3W;
    logic [31:0] ResultW;
    logic        cp_valid;
    logic [3:0]  cp_wa;
    logic [31:0] cp_data;
    logic        cp_ready;
    logic        rf_we;
    logic [3:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [15:0] pend_mask;
    logic        stall_req;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0]  wa;
        logic [31:0] data;
        bit          killed;
    } ent_t;

    ent_t mq[$];
    int   blocked = 0;
    bit   starved = 0;

    wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .RegWriteW(RegWriteW), .WA3W(WA3W), .ResultW(ResultW),
        .cp_valid(cp_valid), .cp_wa(cp_wa), .cp_data(cp_data),
        .cp_ready(cp_ready), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .pend_mask(pend_mask), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: the queue advances on each edge according to the arbitration rules.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            mq.delete();
            blocked = 0;
            starved = 0;
        end else begin
            bit hv, hl, iss, drop, psh;
            ent_t e;
            hv   = (mq.size() > 0);
            hl   = hv ? !mq[0].killed : 1'b0;
            drop = hv ? mq[0].killed : 1'b0;
            iss  = hl && !RegWriteW;
            psh  = cp_valid && (mq.size() < DEPTH);
            if (starved) begin
                if (iss || drop) begin
                    starved = 0;
                    blocked = 0;
                end
            end else if (!hv || iss) begin
                blocked = 0;
            end else if (hl && RegWriteW) begin
                blocked++;
                if (blocked >= STARVE_LIMIT) starved = 1;
            end
            if (RegWriteW) begin
                foreach (mq[i]) if (mq[i].wa == WA3W) mq[i].killed = 1;
            end
            if (iss || drop) void'(mq.pop_front());
            if (psh) begin
                e.wa = cp_wa;
                e.data = cp_data;
                e.killed = 0;
                mq.push_back(e);
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    initial forever begin
        logic        e_we, e_rdy, e_st;
        logic [3:0]  e_wa;
        logic [31:0] e_wd;
        logic [15:0] e_pm;
        @(negedge clk);
        e_rdy = (mq.size() < DEPTH);
        e_st  = starved;
        e_pm  = '0;
        foreach (mq[i]) if (!mq[i].killed) e_pm[mq[i].wa] = 1'b1;
        e_we = 1'b0; e_wa = 4'd0; e_wd = 32'd0;
        if (RegWriteW) begin
            e_we = 1'b1; e_wa = WA3W; e_wd = ResultW;
        end else if (mq.size() > 0 && !mq[0].killed) begin
            e_we = 1'b1; e_wa = mq[0].wa; e_wd = mq[0].data;
        end
        cmp("model_rf_we", 32'(rf_we), 32'(e_we));
        cmp("model_rf_wa", 32'(rf_wa), 32'(e_wa));
        cmp("model_rf_wd", rf_wd, e_wd);
        cmp("model_pend_mask", 32'(pend_mask), 32'(e_pm));
        cmp("model_stall_req", 32'(stall_req), 32'(e_st));
        cmp("model_cp_ready", 32'(cp_ready), 32'(e_rdy));
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        RegWriteW = 0; WA3W = 0; ResultW = 0;
        cp_valid = 0; cp_wa = 0; cp_data = 0;
        repeat (2) @(posedge clk);
        #1;
        mid();
        cmp("rst_rf_we", 32'(rf_we), 32'd0);
        cmp("rst_pend", 32'(pend_mask), 32'd0);
        cmp("rst_stall", 32'(stall_req), 32'd0);
        cmp("rst_ready", 32'(cp_ready), 32'd1);
        nxt();
        rst = 0;
        nxt();

        // Single push into an idle pipeline.
        cp_valid = 1; cp_wa = 4'd3; cp_data = 32'hDEADBEEF;
        mid();
        cmp("s1_no_bypass", 32'(rf_we), 32'd0);
        nxt();
        cp_valid = 0;
        mid();
        cmp("s1_we", 32'(rf_we), 32'd1);
        cmp("s1_wa", 32'(rf_wa), 32'd3);
        cmp("s1_wd", rf_wd, 32'hDEADBEEF);
        cmp("s1_pend", 32'(pend_mask), 32'h0008);
        nxt();
        mid();
        cmp("s1_idle_we", 32'(rf_we), 32'd0);
        cmp("s1_idle_pend", 32'(pend_mask), 32'd0);
        nxt();

        // Two pushes while the pipeline holds the port: starvation.
        RegWriteW = 1; WA3W = 4'd1; ResultW = 32'h100;
        cp_valid = 1; cp_wa = 4'd5; cp_data = 32'h5555;
        nxt();
        cp_wa = 4'd6; cp_data = 32'h6666;
        mid();
        cmp("s2_ready_one", 32'(cp_ready), 32'd1);
        nxt();
        cp_valid = 0;
        mid();
        cmp("s2_ready_full", 32'(cp_ready), 32'd0);
        cmp("s2_pend", 32'(pend_mask), 32'h0060);
        cmp("s2_pipe_wa", 32'(rf_wa), 32'd1);
        cmp("s2_stall_early", 32'(stall_req), 32'd0);
        nxt(); nxt();
        mid();
        cmp("s2_stall_3", 32'(stall_req), 32'd0);
        nxt();
        mid();
        cmp("s2_stall_4", 32'(stall_req), 32'd1);
        nxt();
        RegWriteW = 0;
        mid();
        cmp("s2_r5_we", 32'(rf_we), 32'd1);
        cmp("s2_r5_wa", 32'(rf_wa), 32'd5);
        cmp("s2_r5_wd", rf_wd, 32'h5555);
        nxt();
        mid();
        cmp("s2_r6_wa", 32'(rf_wa), 32'd6);
        cmp("s2_r6_wd", rf_wd, 32'h6666);
        cmp("s2_stall_clr", 32'(stall_req), 32'd0);
        cmp("s2_ready_back", 32'(cp_ready), 32'd1);
        nxt();
        mid();
        cmp("s2_drained", 32'(rf_we), 32'd0);
        nxt();

        // WAW kill of a queued entry by the pipeline.
        cp_valid = 1; cp_wa = 4'd7; cp_data = 32'h7777;
        nxt();
        cp_valid = 0; RegWriteW = 1; WA3W = 4'd7; ResultW = 32'h11;
        mid();
        cmp("s3_wa", 32'(rf_wa), 32'd7);
        cmp("s3_wd", rf_wd, 32'h11);
        cmp("s3_pend_set", 32'(pend_mask), 32'h0080);
        nxt();
        RegWriteW = 0;
        mid();
        cmp("s3_killed_nowrite", 32'(rf_we), 32'd0);
        cmp("s3_pend_clr", 32'(pend_mask), 32'd0);
        nxt();
        mid();
        cmp("s3_after_pop", 32'(rf_we), 32'd0);
        nxt();

        // Same-cycle pipeline write and push to the same register.
        RegWriteW = 1; WA3W = 4'd2; ResultW = 32'h22;
        cp_valid = 1; cp_wa = 4'd2; cp_data = 32'h2222;
        mid();
        cmp("s4_pipe_wd", rf_wd, 32'h22);
        nxt();
        RegWriteW = 0; cp_valid = 0;
        mid();
        cmp("s4_cp_we", 32'(rf_we), 32'd1);
        cmp("s4_cp_wa", 32'(rf_wa), 32'd2);
        cmp("s4_cp_wd", rf_wd, 32'h2222);
        nxt();
        mid();
        cmp("s4_done", 32'(rf_we), 32'd0);
        nxt();

        // Full FIFO drain with a held offer, repeated across pointer wrap.
        for (int k = 0; k < 5; k++) begin
            RegWriteW = 1; WA3W = 4'd0; ResultW = 32'h0;
            cp_valid = 1; cp_wa = 4'(k + 8); cp_data = 32'hA00 + 32'(k);
            nxt();
            cp_wa = 4'(k + 9); cp_data = 32'hB00 + 32'(k);
            nxt();
            RegWriteW = 0;
            cp_wa = 4'(k + 10); cp_data = 32'hC00 + 32'(k);
            mid();
            cmp("s5_full_ready", 32'(cp_ready), 32'd0);
            cmp("s5_head_a", rf_wd, 32'hA00 + 32'(k));
            nxt();
            mid();
            cmp("s5_ready_again", 32'(cp_ready), 32'd1);
            cmp("s5_head_b", rf_wd, 32'hB00 + 32'(k));
            nxt();
            cp_valid = 0;
            mid();
            cmp("s5_head_c", rf_wd, 32'hC00 + 32'(k));
            nxt();
            mid();
            cmp("s5_empty", 32'(rf_we), 32'd0);
            nxt();
        end

        // Reset while starved with two entries queued.
        RegWriteW = 1; WA3W = 4'd0; ResultW = 32'h0;
        cp_valid = 1; cp_wa = 4'd11; cp_data = 32'hBBBB;
        nxt();
        cp_wa = 4'd12; cp_data = 32'hCCCC;
        nxt();
        cp_valid = 0;
        nxt(); nxt(); nxt();
        mid();
        cmp("s6_stall", 32'(stall_req), 32'd1);
        cmp("s6_pend", 32'(pend_mask), 32'h1800);
        nxt();
        RegWriteW = 0;
        rst = 1;
        #1;
        cmp("s6_rst_stall", 32'(stall_req), 32'd0);
        cmp("s6_rst_pend", 32'(pend_mask), 32'd0);
        cmp("s6_rst_ready", 32'(cp_ready), 32'd1);
        cmp("s6_rst_we", 32'(rf_we), 32'd0);
        nxt();
        rst = 0;
        mid();
        cmp("s6_no_stale_1", 32'(rf_we), 32'd0);
        nxt();
        mid();
        cmp("s6_no_stale_2", 32'(rf_we), 32'd0);
        cmp("s6_pend_after", 32'(pend_mask), 32'd0);
        nxt();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the pipeline writeback stage and a multi-cycle coprocessor (modular-exponentiation unit) that returns results asynchronously to the pipeline.
- The pipeline writeback always has priority. Coprocessor results are queued in a small FIFO and drained into idle writeback cycles.
- Provides a pending-register scoreboard for the hazard unit.
- Raises a stall request when queued results have been starved too long.

Parameters:
- DEPTH, 2, number of coprocessor result entries held (power of 2, ≥2).
- STARVE_LIMIT, 4, consecutive non-issuing cycles with a valid queued head before stall_req asserts (≥1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- RegWriteW  in  1  pipeline writeback write enable.
- WA3W  in  4  pipeline writeback destination register.
- ResultW  in  32  pipeline writeback data.
- cp_valid  in  1  coprocessor result offered.
- cp_wa  in  4  coprocessor destination register.
- cp_data  in  32  coprocessor result data.
- cp_ready  out  1  FIFO can accept; equals not-full.
- rf_we  out  1  register-file write enable.
- rf_wa  out  4  register-file write address.
- rf_wd  out  32  register-file write data.
- pend_mask  out  16  bit r set when a live (non-killed) queued entry targets register r.
- stall_req  out  1  request to the hazard unit to insert writeback bubbles.

Behaviour:
- Reset:
  - FIFO emptied; all kill bits, starve counter and FSM cleared (state NORMAL).
  - Outputs during and after reset: rf_we=0 (when RegWriteW=0), pend_mask=0, stall_req=0, cp_ready=1.
- Write-port mux (combinational):
  - If RegWriteW=1: rf_we=1, rf_wa=WA3W, rf_wd=ResultW.
  - Else if head is valid and live: rf_we=1, rf_wa/rf_wd from the head (an issue).
  - Else rf_we=0, rf_wa=0, rf_wd=0.
- Push:
  - cp_valid&cp_ready captures {cp_wa, cp_data} at the rising edge.
  - Minimum latency from push to issue is 1 cycle; there is no same-cycle bypass.
  - cp_data must not be dropped: if cp_ready=0, the coprocessor holds its offer.
- Pop:
  - The head pops at the edge after an issue cycle.
  - A killed head pops at the next edge without writing, regardless of RegWriteW.
  - A push and a pop may occur in the same cycle, including when the FIFO is full (cp_ready is computed from the current count only, so no push when full).
- Kill (write-after-write ordering):
  - When RegWriteW=1 and an entry already in the FIFO targets WA3W, that entry's kill bit is set at the edge.
  - An entry pushed in that same cycle is not killed.
- pend_mask: OR of one-hot(wa) over valid entries whose kill bit is clear, registered state only.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- Starvation FSM:
  - NORMAL: the counter increments each cycle in which the head is valid and live but RegWriteW=1. It clears on an issue or when the FIFO is empty. When the counter reaches STARVE_LIMIT, go to STARVED.
  - STARVED: stall_req=1 (registered). The FSM stays until an issue occurs, then returns to NORMAL with the counter cleared.
  - If the head is killed while in STARVED, return to NORMAL.
  - The pipeline keeps priority in STARVED; stall_req only asks for bubbles.
- Reset mid-operation: all queued entries are discarded with no write, and stall_req deasserts immediately (asynchronously).

Test Plan:
- Idle pipeline, push cp_wa=3, cp_data=0xDEADBEEF → next cycle rf_we=1, rf_wa=3, rf_wd=0xDEADBEEF; pend_mask=0x0008 for exactly 1 cycle; the FIFO is then empty.
- Push cp_wa=5 and cp_wa=6 back-to-back with RegWriteW=1 held → cp_ready=0 after the 2nd push; pend_mask=0x0060; stall_req=1 after 4 blocked cycles. Drop RegWriteW → R5 is written, then R6, stall_req returns to 0 after the R5 issue, and cp_ready returns to 1.
- Queue cp_wa=7, then pipeline RegWriteW=1, WA3W=7, ResultW=0x11 → rf write of 0x11 to R7; pend_mask bit 7 clears; the queued entry pops with no write.
- Same cycle: RegWriteW=1, WA3W=2 and push cp_wa=2 → the pipeline writes R2 now; the coprocessor entry is not killed and writes R2 in the next idle cycle.
- Full FIFO with RegWriteW=0 and cp_valid=1 → the head issues while cp_ready=0 blocks the push; the push is accepted in the following cycle; the sequence is stable across pointer wrap (repeat 5 times).
- Assert rst for 1 cycle with 2 entries queued and stall_req=1 → stall_req and pend_mask are 0 immediately, cp_ready=1, and no stale write occurs afterwards.
